// File: rtl/motor_ramp_sequencer_pkg.sv
// Shared types and default timing for the stepper ramp sequencer.
// Speed width matches the MotorDriver speed input.
package motor_ramp_sequencer_pkg;

  localparam int SPEED_W = 10;
  localparam int CNT_W   = 32;

  localparam int DEF_MAX_SPEED        = 400;
  localparam int DEF_STEP             = 25;
  localparam int DEF_RAMP_DIV         = 1_000_000;
  localparam int DEF_SETTLE_CYCLES    = 100_000;
  localparam int DEF_DIR_SETUP_CYCLES = 100;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    RAMP,
    HOLD,
    FLIP
  } state_t;

  // Move cur toward goal by at most step, landing exactly on goal when closer.
  function automatic speed_t step_toward(input speed_t cur, input speed_t goal, input speed_t step);
    speed_t diff;
    if (goal > cur) begin
      diff = goal - cur;
      return cur + ((diff < step) ? diff : step);
    end else begin
      diff = cur - goal;
      return cur - ((diff < step) ? diff : step);
    end
  endfunction

endpackage

// File: rtl/motor_ramp_sequencer_ramp_tick.sv
// Free-running divider producing a one-cycle tick every 'load' cycles.
// Clearing restarts the period so the first tick lands 'load' cycles later.
module ramp_tick
  import motor_ramp_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] load,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  assign tick = (count == load - CNT_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Command latch, bounded-acceleration ramp and reversal sequencing for one
// stepper channel feeding a MotorDriver.
module motor_ramp_sequencer
  import motor_ramp_sequencer_pkg::*;
#(
  parameter int MAX_SPEED        = DEF_MAX_SPEED,
  parameter int STEP             = DEF_STEP,
  parameter int RAMP_DIV         = DEF_RAMP_DIV,
  parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
  parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES
)
(
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SPEED_W-1:0] cmd_speed,
  input  logic               cmd_dir,
  input  logic               cmd_enable,
  input  logic               estop,
  output logic [SPEED_W-1:0] speed,
  output logic               dir,
  output logic               run_en,
  output logic               busy
);

  localparam speed_t MAX_S  = speed_t'(MAX_SPEED);
  localparam speed_t STEP_S = speed_t'(STEP);

  state_t           state;
  state_t           state_nxt;
  speed_t           speed_nxt;
  logic             dir_nxt;
  speed_t           tgt_speed;
  logic             tgt_dir;
  logic             tgt_en;
  speed_t           goal;
  logic             tick;
  logic             tick_clear;
  logic [CNT_W-1:0] tick_load;

  assign cmd_ready = (state != FLIP);
  assign run_en    = (state != IDLE);
  assign busy      = (state inside {WAKE, RAMP, FLIP});

  // A reversal is expressed as a goal of zero until the direction has flipped.
  assign goal = (tgt_en && (tgt_dir == dir)) ? tgt_speed : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tgt_speed <= '0;
      tgt_dir   <= 1'b1;
      tgt_en    <= 1'b0;
    end else if (estop) begin
      tgt_en <= 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      tgt_speed <= (cmd_speed > MAX_S) ? MAX_S : cmd_speed;
      tgt_dir   <= cmd_dir;
      tgt_en    <= cmd_enable;
    end
  end

  // One divider serves the wake settle, the direction setup and the ramp period.
  always_comb begin
    case (state)
      WAKE:    tick_load = CNT_W'(SETTLE_CYCLES);
      FLIP:    tick_load = CNT_W'(DIR_SETUP_CYCLES);
      default: tick_load = CNT_W'(RAMP_DIV);
    endcase
  end

  assign tick_clear = (state_nxt != state);

  ramp_tick u_ramp_tick (
    .clock (clock),
    .reset (reset),
    .clear (tick_clear),
    .load  (tick_load),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      speed <= '0;
      dir   <= 1'b1;
    end else begin
      state <= state_nxt;
      speed <= speed_nxt;
      dir   <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    speed_nxt = speed;
    dir_nxt   = dir;
    if (estop) begin
      state_nxt = IDLE;
      speed_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          speed_nxt = '0;
          if (tgt_en) begin
            dir_nxt   = tgt_dir;
            state_nxt = WAKE;
          end
        end
        WAKE: begin
          if (!tgt_en) begin
            state_nxt = IDLE;
          end else if (tick) begin
            state_nxt = RAMP;
          end
        end
        RAMP: begin
          // Arrival is acted on immediately; otherwise speed only moves on a tick.
          if (speed == goal) begin
            if ((goal == '0) && !tgt_en) begin
              state_nxt = IDLE;
            end else if ((goal == '0) && (tgt_dir != dir)) begin
              state_nxt = FLIP;
              dir_nxt   = tgt_dir;
            end else begin
              state_nxt = HOLD;
            end
          end else if (tick) begin
            speed_nxt = step_toward(speed, goal, STEP_S);
          end
        end
        HOLD: begin
          if ((goal != speed) || !tgt_en || (tgt_dir != dir)) begin
            state_nxt = RAMP;
          end
        end
        FLIP: begin
          if (tick) begin
            state_nxt = RAMP;
          end
        end
        default: begin
          state_nxt = IDLE;
          speed_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed and randomized checks of motor_ramp_sequencer against a schedule
// model derived from the ramp, settle and reversal timing rules.
module tb_motor_ramp_sequencer;

  localparam int RAMP_DIV  = 4;
  localparam int STEP      = 50;
  localparam int SETTLE    = 8;
  localparam int DIR_SETUP = 3;
  localparam int MAX_SPEED = 400;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_speed;
  logic       cmd_dir;
  logic       cmd_enable;
  logic       estop;
  logic [9:0] speed;
  logic       dir;
  logic       run_en;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int mSpeed   = 0;
  int mDir     = 1;

  motor_ramp_sequencer #(
    .MAX_SPEED        (MAX_SPEED),
    .STEP             (STEP),
    .RAMP_DIV         (RAMP_DIV),
    .SETTLE_CYCLES    (SETTLE),
    .DIR_SETUP_CYCLES (DIR_SETUP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_speed  (cmd_speed),
    .cmd_dir    (cmd_dir),
    .cmd_enable (cmd_enable),
    .estop      (estop),
    .speed      (speed),
    .dir        (dir),
    .run_en     (run_en),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One-cycle command strobe; returns just after the accepting edge.
  task automatic applyStimulus(input int spd, input int d, input int en);
    cmd_speed  = 10'(spd);
    cmd_dir    = d[0];
    cmd_enable = en[0];
    cmd_valid  = 1'b1;
    step(1);
    cmd_valid  = 1'b0;
  endtask

  function automatic int clampSpeed(input int s);
    return (s > MAX_SPEED) ? MAX_SPEED : s;
  endfunction

  // Called just after RAMP is entered: one bounded step per RAMP_DIV cycles.
  task automatic followRamp(input int goal);
    int s;
    int nxt;
    s = mSpeed;
    while (s != goal) begin
      if (goal > s) nxt = s + (((goal - s) < STEP) ? (goal - s) : STEP);
      else          nxt = s - (((s - goal) < STEP) ? (s - goal) : STEP);
      step(RAMP_DIV - 1);
      checkOutput("ramp_hold", speed, s);
      step(1);
      checkOutput("ramp_step", speed, nxt);
      checkOutput("ramp_dir", dir, mDir);
      checkOutput("ramp_run_en", run_en, 1);
      s = nxt;
    end
    mSpeed = goal;
  endtask

  task automatic settleHold();
    step(1);
    checkOutput("hold_busy", busy, 0);
    checkOutput("hold_run_en", run_en, 1);
    checkOutput("hold_speed", speed, mSpeed);
    checkOutput("hold_ready", cmd_ready, 1);
  endtask

  // From IDLE: enable command, wake delay; returns just after RAMP entry.
  task automatic startFromIdle(input int spd, input int d);
    applyStimulus(spd, d, 1);
    checkOutput("idle_run_en", run_en, 0);
    step(1);
    checkOutput("wake_run_en", run_en, 1);
    checkOutput("wake_busy", busy, 1);
    checkOutput("wake_dir", dir, d);
    mDir = d;
    step(SETTLE - 1);
    checkOutput("wake_speed", speed, 0);
    step(1);
  endtask

  // From HOLD: retarget, including a full reversal when the direction differs.
  task automatic driveCommand(input int spd, input int d);
    int goal;
    goal = clampSpeed(spd);
    applyStimulus(spd, d, 1);
    if (d == mDir) begin
      if (goal == mSpeed) begin
        step(2);
        checkOutput("hold_keep_speed", speed, mSpeed);
        checkOutput("hold_keep_busy", busy, 0);
      end else begin
        step(1);
        followRamp(goal);
        settleHold();
      end
    end else begin
      step(1);
      followRamp(0);
      checkOutput("flip_dir_late", dir, mDir);
      step(1);
      checkOutput("flip_dir", dir, d);
      checkOutput("flip_ready", cmd_ready, 0);
      checkOutput("flip_run_en", run_en, 1);
      checkOutput("flip_speed", speed, 0);
      mDir = d;
      step(DIR_SETUP - 1);
      checkOutput("flip_ready_end", cmd_ready, 0);
      step(1);
      checkOutput("flip_ready_back", cmd_ready, 1);
      followRamp(goal);
      settleHold();
    end
  endtask

  // From HOLD: disable, ramp to zero, then de-energise.
  task automatic disableRamp();
    applyStimulus(0, mDir, 0);
    step(1);
    followRamp(0);
    checkOutput("off_run_en_at_zero", run_en, 1);
    step(1);
    checkOutput("off_run_en", run_en, 0);
    checkOutput("off_busy", busy, 0);
    checkOutput("off_speed", speed, 0);
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_speed  = '0;
    cmd_dir    = 1'b1;
    cmd_enable = 1'b0;
    estop      = 1'b0;
    step(2);
    checkOutput("rst_speed", speed, 0);
    checkOutput("rst_dir", dir, 1);
    checkOutput("rst_run_en", run_en, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    reset = 1'b0;
    step(2);
    checkOutput("idle_stays", run_en, 0);

    // Start from rest, then a clipped slow-down, then a reversal
    startFromIdle(200, 1);
    followRamp(200);
    settleHold();
    driveCommand(120, 1);
    driveCommand(200, 1);
    driveCommand(100, 0);

    // Clamp to the maximum, then disable
    driveCommand(1023, 0);
    checkOutput("clamp_speed", speed, MAX_SPEED);
    disableRamp();

    // Randomized retargets, including reversals and clamps
    mSpeed = 0;
    startFromIdle(250, 1);
    followRamp(250);
    settleHold();
    for (int i = 0; i < 8; i++) begin
      driveCommand(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)));
    end
    disableRamp();

    // Emergency stop mid-ramp with a command held during the stop
    mSpeed = 0;
    startFromIdle(300, 1);
    step(RAMP_DIV * 3);
    checkOutput("pre_estop_speed", speed, 150);
    estop      = 1'b1;
    cmd_speed  = 10'd400;
    cmd_dir    = 1'b1;
    cmd_enable = 1'b1;
    cmd_valid  = 1'b1;
    step(1);
    checkOutput("estop_speed", speed, 0);
    checkOutput("estop_run_en", run_en, 0);
    checkOutput("estop_busy", busy, 0);
    step(3);
    checkOutput("estop_hold_run_en", run_en, 0);
    estop     = 1'b0;
    cmd_valid = 1'b0;
    step(4);
    checkOutput("estop_cmd_ignored", run_en, 0);
    checkOutput("estop_after_speed", speed, 0);

    // Asynchronous reset during a direction flip, then a clean restart
    mSpeed = 0;
    startFromIdle(200, 1);
    followRamp(200);
    settleHold();
    applyStimulus(100, 0, 1);
    step(1);
    followRamp(0);
    step(1);
    checkOutput("pre_reset_in_flip", cmd_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_speed", speed, 0);
    checkOutput("async_rst_dir", dir, 1);
    checkOutput("async_rst_run_en", run_en, 0);
    checkOutput("async_rst_ready", cmd_ready, 1);
    checkOutput("async_rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    step(1);
    mSpeed = 0;
    mDir   = 1;
    startFromIdle(200, 1);
    followRamp(200);
    settleHold();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
